// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: enables a byte source for one RGB frame, packs bytes into
// row/col-tagged pixels and buffers them in a 2-entry FIFO. FRAME_CAPTURE_CONTINUOUS_EN selects free-running capture.

module frame_capture_ctrl #(
    parameter int N = 5,
    parameter int M = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        pix_ready,
    output logic        camera_en,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [7:0]  pix_row,
    output logic [7:0]  pix_col,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);

    localparam int TOTAL = 3 * N * M;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST_EN  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] BYTES    = CW'(TOTAL);
    localparam logic [7:0]    LAST_COL = 8'(M - 1);
    localparam logic [7:0]    LAST_ROW = 8'(N - 1);

`ifdef FRAME_CAPTURE_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
    } pixel_t;

    state_t          state;
    logic [CW-1:0]   en_cnt;
    logic [CW-1:0]   byte_cnt;
    logic [1:0]      lane;
    logic [7:0]      row_cnt;
    logic [7:0]      col_cnt;
    logic [7:0]      r_byte;
    logic [7:0]      g_byte;
    pixel_t          fifo_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      fifo_cnt;

    logic   enter_capture;
    logic   clear_overrun;
    logic   accept;
    logic   push;
    logic   pop;
    logic   full;
    logic   wr_en;
    logic   drop;
    pixel_t new_pix;
    pixel_t head;

    assign enter_capture = (state == IDLE && start) || (state == DONE && CONTINUOUS);
    assign clear_overrun = (state == IDLE) && start;
    assign accept        = data_valid && (state == CAPTURE || state == FLUSH);
    assign push          = accept && (lane == 2'd2);
    assign pop           = pix_valid && pix_ready;
    assign full          = (fifo_cnt == 2'd2);
    // A full FIFO still takes the new pixel when the head leaves on the same edge.
    assign wr_en         = push && (!full || pop);
    assign drop          = push && full && !pop;
    assign new_pix       = '{data: {r_byte, g_byte, data_in}, row: row_cnt, col: col_cnt};

    assign head      = fifo_mem[rd_ptr];
    assign pix_valid = (fifo_cnt != 2'd0);
    assign pix_data  = head.data;
    assign pix_row   = head.row;
    assign pix_col   = head.col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            camera_en  <= 1'b0;
            en_cnt     <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CAPTURE;
                        camera_en <= 1'b1;
                        busy      <= 1'b1;
                        en_cnt    <= '0;
                    end
                end
                CAPTURE: begin
                    if (en_cnt == LAST_EN) begin
                        state     <= FLUSH;
                        camera_en <= 1'b0;
                    end else begin
                        en_cnt <= en_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (byte_cnt == BYTES && fifo_cnt == 2'd0) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    if (CONTINUOUS) begin
                        state     <= CAPTURE;
                        camera_en <= 1'b1;
                        en_cnt    <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the FIFO storage is reset too, because the head drives pix_data directly and must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            lane     <= 2'd0;
            row_cnt  <= 8'd0;
            col_cnt  <= 8'd0;
            r_byte   <= 8'd0;
            g_byte   <= 8'd0;
            overrun  <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            if (enter_capture) begin
                byte_cnt <= '0;
                lane     <= 2'd0;
                row_cnt  <= 8'd0;
                col_cnt  <= 8'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
                case (lane)
                    2'd0: begin
                        r_byte <= data_in;
                        lane   <= 2'd1;
                    end
                    2'd1: begin
                        g_byte <= data_in;
                        lane   <= 2'd2;
                    end
                    default: begin
                        lane <= 2'd0;
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= 8'd0;
                            row_cnt <= (row_cnt == LAST_ROW) ? 8'd0 : row_cnt + 8'd1;
                        end else begin
                            col_cnt <= col_cnt + 8'd1;
                        end
                    end
                endcase
            end

            if (clear_overrun) overrun <= 1'b0;
            else if (drop)     overrun <= 1'b1;

            if (wr_en) begin
                fifo_mem[wr_ptr] <= new_pix;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: a source model feeds bytes one cycle after each
// enable cycle, the test queues expected pixels and a monitor compares every popped pixel.

module tb_frame_capture_ctrl;

    localparam int N     = 5;
    localparam int M     = 5;
    localparam int TOTAL = 3 * N * M;
    localparam int PIX   = N * M;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        pix_ready;
    logic        camera_en;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic [7:0]  pix_row;
    logic [7:0]  pix_col;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    frame_capture_ctrl #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_valid (data_valid),
        .data_in    (data_in),
        .pix_ready  (pix_ready),
        .camera_en  (camera_en),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] sb_q[$];
    int          src_idx  = 0;
    int          cur_byte = -1;
    int          fd_cnt   = 0;
    int          en_cyc   = 0;
    int          pix_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int idx);
        return 8'((idx * 37 + 11) % 256);
    endfunction

    function automatic logic [39:0] exp_pix(input int base, input int i);
        return {fb(base + 3 * i), fb(base + 3 * i + 1), fb(base + 3 * i + 2), 8'(i / M), 8'(i % M)};
    endfunction

    task automatic push_frame(input int base, input int npix);
        for (int i = 0; i < npix; i++) sb_q.push_back(exp_pix(base, i));
    endtask

    // Source: one byte per enable cycle, presented during the following cycle.
    initial begin
        logic en_q;
        data_valid = 1'b0;
        data_in    = 8'd0;
        forever begin
            @(negedge clk);
            en_q = camera_en;
            @(posedge clk);
            #1;
            if (en_q) begin
                data_valid = 1'b1;
                data_in    = fb(src_idx);
                cur_byte   = src_idx;
                src_idx++;
            end else begin
                data_valid = 1'b0;
            end
        end
    end

    // Monitor: compare each transferred pixel and the stability of a stalled head.
    initial begin
        logic [39:0] held;
        logic [39:0] cur;
        bit          stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            cur = {pix_data, pix_row, pix_col};
            if (!rst) begin
                if (camera_en)  en_cyc++;
                if (frame_done) fd_cnt++;
                if (stall) check("hold", {pix_valid, cur}, {1'b1, held});
                if (pix_valid && pix_ready) begin
                    pix_cnt++;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pixel: got %0h required none", cur);
                    end else begin
                        check("pixel", cur, sb_q.pop_front());
                    end
                end
            end
            stall = !rst && pix_valid && !pix_ready;
            held  = cur;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_frames(input int nf, input bit toggle);
        int target;
        target = fd_cnt + nf;
        for (int c = 0; c < 400 * nf && fd_cnt < target; c++) begin
            @(posedge clk);
            #1;
            if (toggle) pix_ready = ~pix_ready;
        end
        check("frame_timeout", 64'(fd_cnt >= target), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_byte_on_bus(input int idx);
        for (int c = 0; c < 200 && !(data_valid && cur_byte == idx); c++) @(negedge clk);
        check("byte_wait", 64'(data_valid && cur_byte == idx), 1);
    endtask

    initial begin
        int base;
        int f0;
        int e0;
        int p0;
        rst       = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {camera_en, pix_valid, pix_data, pix_row, pix_col, frame_done, busy, overrun}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_start", {camera_en, busy, pix_valid}, 0);

`ifdef FRAME_CAPTURE_CONTINUOUS_EN
        base = src_idx; f0 = fd_cnt; p0 = pix_cnt;
        for (int f = 0; f < 3; f++) push_frame(base + f * TOTAL, PIX);
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 400 && !frame_done; c++) @(negedge clk);
            check("cont_frame_done", 64'(frame_done), 1);
            @(negedge clk);
            check("cont_rerise", {camera_en, frame_done}, 2'b10);
        end
        check("cont_frames", fd_cnt - f0, 3);
        check("cont_pixels", pix_cnt - p0, 3 * PIX);
        #2 rst = 1'b1;
        #1 check("cont_reset", {camera_en, pix_valid, busy, overrun}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`else
        // Full frame with the consumer always ready.
        base = src_idx; f0 = fd_cnt; e0 = en_cyc; p0 = pix_cnt;
        push_frame(base, PIX);
        pulse_start();
        @(negedge clk);
        check("t1_busy", {busy, camera_en}, 2'b11);
        run_frames(1, 1'b0);
        check("t1_en_cycles", en_cyc - e0, TOTAL);
        check("t1_frames", fd_cnt - f0, 1);
        check("t1_pixels", pix_cnt - p0, PIX);
        check("t1_end", {busy, overrun, camera_en}, 0);

        // Consumer stalled for the whole capture: two pixels buffered, the rest dropped.
        pix_ready = 1'b0;
        base = src_idx; f0 = fd_cnt; p0 = pix_cnt;
        push_frame(base, 2);
        pulse_start();
        wait_byte_on_bus(base + 8);
        check("t2_pre_overrun", {overrun, pix_valid, pix_data}, {2'b01, exp_pix(base, 0)[39:16]});
        @(negedge clk);
        check("t2_overrun", 64'(overrun), 1);
        repeat (100) @(negedge clk);
        check("t2_flush_wait", {busy, overrun, pix_valid, pix_row, pix_col}, {3'b111, 16'h0000});
        check("t2_no_done", fd_cnt - f0, 0);
        @(posedge clk);
        #1 pix_ready = 1'b1;
        run_frames(1, 1'b0);
        check("t2_pixels", pix_cnt - p0, 2);
        check("t2_sticky", {overrun, busy}, 2'b10);

        // Consumer ready on alternate cycles.
        base = src_idx; p0 = pix_cnt; e0 = en_cyc;
        push_frame(base, PIX);
        pulse_start();
        @(negedge clk);
        check("t3_overrun_clear", 64'(overrun), 0);
        run_frames(1, 1'b1);
        pix_ready = 1'b1;
        check("t3_pixels", pix_cnt - p0, PIX);
        check("t3_overrun", 64'(overrun), 0);
        check("t3_en_cycles", en_cyc - e0, TOTAL);

        // Extra start pulses while capturing are ignored.
        base = src_idx; f0 = fd_cnt; e0 = en_cyc;
        push_frame(base, PIX);
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_start();
        repeat (40) @(posedge clk);
        pulse_start();
        run_frames(1, 1'b0);
        repeat (5) @(negedge clk);
        check("t4_en_cycles", en_cyc - e0, TOTAL);
        check("t4_frames", fd_cnt - f0, 1);
        check("t4_idle", {busy, camera_en}, 0);

        // Reset in the middle of a frame, then a clean capture.
        base = src_idx;
        push_frame(base, 10);
        pulse_start();
        wait_byte_on_bus(base + 29);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("t5_async_reset", {camera_en, pix_valid, pix_data, pix_row, pix_col, frame_done, busy, overrun}, 0);
        check("t5_queue", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_quiet", {camera_en, busy, pix_valid}, 0);
        base = src_idx; f0 = fd_cnt; p0 = pix_cnt; e0 = en_cyc;
        push_frame(base, PIX);
        pulse_start();
        run_frames(1, 1'b0);
        check("t5_pixels", pix_cnt - p0, PIX);
        check("t5_en_cycles", en_cyc - e0, TOTAL);
`endif

        check("queue_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 Parameter N, default 5: frame height in rows.
REQ-002 Parameter M, default 5: frame width in pixels per row; one frame = 3*N*M bytes.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to capture a frame.
REQ-006 data_valid  input  1  byte strobe from the camera/image source.
REQ-007 data_in  input  8  source byte; order R,G,B per pixel, row-major.
REQ-008 pix_ready  input  1  downstream accepts pix_data this cycle.
REQ-009 camera_en  output  1  source enable (registered).
REQ-010 pix_valid  output  1  pix_data/pix_row/pix_col hold a valid pixel.
REQ-011 pix_data  output  24  {R,G,B}, R in [23:16].
REQ-012 pix_row  output  8  row index 0..N-1 of pix_data.
REQ-013 pix_col  output  8  column index 0..M-1 of pix_data.
REQ-014 frame_done  output  1  one-cycle pulse at end of frame.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 overrun  output  1  sticky flag: a pixel was dropped.

Function
REQ-017 FSM states IDLE, CAPTURE, FLUSH, DONE; encoding free.
REQ-018 IDLE + start -> CAPTURE next edge; camera_en rises on that edge; overrun clears on that edge.
REQ-019 start outside IDLE is ignored.
REQ-020 CAPTURE: camera_en high for exactly 3*N*M consecutive cycles (enable counter); after the last enable cycle -> FLUSH, camera_en low.
REQ-021 Source latency: one byte per enable cycle, arriving one cycle later; data_valid accepted only in CAPTURE and FLUSH, ignored in IDLE/DONE.
REQ-022 Byte lane counter 0,1,2 wraps per pixel; lane 2 completes triplet {R,G,B}.
REQ-023 Column counter 0..M-1 wraps to 0 and increments row; row counter 0..N-1; both advance on triplet completion and tag the pixel.
REQ-024 Completed pixels (data+row+col) written into a 2-entry FIFO; head drives pix_data/pix_row/pix_col; pix_valid = FIFO not empty.
REQ-025 Pop when pix_valid && pix_ready; outputs stable while pix_valid && !pix_ready.
REQ-026 Full FIFO + new triplet + pop same cycle: write accepted, no drop.
REQ-027 Full FIFO + new triplet + no pop: new pixel dropped, overrun set, counters still advance.
REQ-028 Empty FIFO + new triplet: pix_valid rises the following cycle (1-cycle latency from lane-2 byte).
REQ-029 FLUSH -> DONE once byte count = 3*N*M and FIFO empty.
REQ-030 DONE lasts one cycle with frame_done=1, then -> IDLE; lane/row/col/byte/enable counters cleared on entering CAPTURE.
REQ-031 pix_data etc. are don't-care but stable when pix_valid=0.

Reset
REQ-032 rst asserted (any state, mid-frame included): immediately IDLE, camera_en=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, frame_done=0, busy=0, overrun=0, FIFO empty, all counters 0.
REQ-033 After rst deasserts, nothing happens until start.

Configuration
REQ-034 Macro FRAME_CAPTURE_CONTINUOUS_EN: when defined, DONE -> CAPTURE directly (camera_en re-rises the cycle after frame_done) until rst; start then only needed from IDLE after reset.
REQ-035 Without FRAME_CAPTURE_CONTINUOUS_EN: DONE -> IDLE, one frame per start.

Verification (N=M=5, 75 bytes, 25 pixels)
REQ-036 rst, start pulse, pix_ready=1 -> camera_en high 75 cycles; 25 pixels, first {b0,b1,b2} row0 col0, last {b72,b73,b74} row4 col4; single frame_done; overrun=0; back to IDLE.
REQ-037 pix_ready=0 throughout -> pix_valid holds pixel 0, FIFO full after pixel 1, overrun set on pixel 2 and stays 1; after releasing pix_ready, pixels 0 and 1 drain, then frame_done.
REQ-038 pix_ready toggling 1/0 every cycle -> all 25 pixels delivered in order, overrun=0.
REQ-039 start re-pulsed during CAPTURE -> ignored; camera_en high exactly 75 cycles, one frame_done.
REQ-040 rst asserted after 30 bytes -> all outputs 0 asynchronously; new start captures from byte 0, first pixel row0 col0.
REQ-041 With FRAME_CAPTURE_CONTINUOUS_EN, one start -> three consecutive frames of 25 pixels each, frame_done every frame, camera_en re-rises one cycle after each frame_done.
